// File: rtl/matrix_addition.sv
// matrix_addition
//   Element-wise addition of two packed ROWS x COLS matrices of unsigned
//   EW-bit elements, registered with a latency of one clock.
//   Element (r,col) sits at bits [k*EW +: EW] with k = r*COLS + col.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        asynchronous, active-high reset (clears c, ovf, out_valid)
//   in_valid   a/b carry an operand pair to be added this cycle
//   a, b       packed operand matrices, ROWS*COLS*EW bits
//   c          registered packed sum matrix
//   out_valid  pulses high the cycle after in_valid was sampled high
//   ovf        registered per-element carry-out, bit k for element k
//
// Configuration
//   MATRIX_ADD_SAT_EN  when defined, an element that carries out saturates
//                      to all-ones instead of wrapping; ovf still flags it.

module matrix_addition #(
  parameter int ROWS = 2,
  parameter int COLS = 2,
  parameter int EW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ROWS*COLS*EW-1:0]  a,
  input  logic [ROWS*COLS*EW-1:0]  b,
  output logic [ROWS*COLS*EW-1:0]  c,
  output logic                     out_valid,
  output logic [ROWS*COLS-1:0]     ovf
);

  localparam int N = ROWS * COLS;

  logic [N*EW-1:0] c_d,   c_q;
  logic [N-1:0]    ovf_d, ovf_q;
  logic            out_valid_d, out_valid_q;

  // Each element is summed in its own EW+1-bit adder so a carry can never
  // leak into the neighbouring element.
  always_comb begin : next_state
    logic [EW:0] sum;
    c_d         = c_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    sum         = '0;
    if (in_valid) begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, a[k*EW +: EW]} + {1'b0, b[k*EW +: EW]};
        ovf_d[k] = sum[EW];
`ifdef MATRIX_ADD_SAT_EN
        c_d[k*EW +: EW] = sum[EW] ? {EW{1'b1}} : sum[EW-1:0];
`else
        c_d[k*EW +: EW] = sum[EW-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      c_q         <= c_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign c         = c_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_addition.sv
// tb_matrix_addition
//   Directed, table-driven bench for matrix_addition (2x2, 4-bit elements).
//   Expected values are hand-computed; the saturating variant is selected
//   with MATRIX_ADD_SAT_EN to match the design build.

module tb_matrix_addition;

`ifdef MATRIX_ADD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic [15:0] c;
  logic        out_valid;
  logic [3:0]  ovf;

  int n_vec = 0;
  int n_err = 0;

  matrix_addition #(.ROWS(2), .COLS(2), .EW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        iv;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_c;
    logic [3:0]  exp_ovf;
    logic        exp_ov;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [15:0] ec,
                           input logic [3:0] eo, input logic ev);
    check({name, ".c"},         {16'h0, c},           {16'h0, ec});
    check({name, ".ovf"},       {28'h0, ovf},         {28'h0, eo});
    check({name, ".out_valid"}, {31'h0, out_valid},   {31'h0, ev});
  endtask

  task automatic add_vec(input string name, input logic iv, input logic [15:0] va,
                         input logic [15:0] vb, input logic [15:0] ec,
                         input logic [3:0] eo, input logic ev);
    vec_t v;
    v.name = name; v.iv = iv; v.a = va; v.b = vb;
    v.exp_c = ec; v.exp_ovf = eo; v.exp_ov = ev;
    vecs.push_back(v);
  endtask

  initial begin
    // Sweep: element 0 = i + (4+i) = 2i+4; i=6,7 carry out of element 0.
    add_vec("sweep0", 1'b1, 16'h0000, 16'h0004, 16'h0004, 4'b0000, 1'b1);
    add_vec("sweep1", 1'b1, 16'h0001, 16'h0005, 16'h0006, 4'b0000, 1'b1);
    add_vec("sweep2", 1'b1, 16'h0002, 16'h0006, 16'h0008, 4'b0000, 1'b1);
    add_vec("sweep3", 1'b1, 16'h0003, 16'h0007, 16'h000A, 4'b0000, 1'b1);
    add_vec("sweep4", 1'b1, 16'h0004, 16'h0008, 16'h000C, 4'b0000, 1'b1);
    add_vec("sweep5", 1'b1, 16'h0005, 16'h0009, 16'h000E, 4'b0000, 1'b1);
    add_vec("sweep6", 1'b1, 16'h0006, 16'h000A, SAT ? 16'h000F : 16'h0000, 4'b0001, 1'b1);
    add_vec("sweep7", 1'b1, 16'h0007, 16'h000B, SAT ? 16'h000F : 16'h0002, 4'b0001, 1'b1);
    // Isolation: every element carries, none may disturb its neighbour.
    add_vec("iso_all", 1'b1, 16'hFFFF, 16'h1111, SAT ? 16'hFFFF : 16'h0000, 4'b1111, 1'b1);
    // Elements 0 and 2 carry; elements 1 and 3 must stay 3 and 7.
    add_vec("iso_mix", 1'b1, 16'h7F3C, 16'h0105, SAT ? 16'h7F3F : 16'h7031, 4'b0101, 1'b1);
    add_vec("hold_ovf", 1'b0, 16'h1234, 16'hAAAA, SAT ? 16'h7F3F : 16'h7031, 4'b0101, 1'b0);
    add_vec("msb_all", 1'b1, 16'h8888, 16'h8888, SAT ? 16'hFFFF : 16'h0000, 4'b1111, 1'b1);
    add_vec("plain", 1'b1, 16'h1234, 16'h4321, 16'h5555, 4'b0000, 1'b1);
    add_vec("hold1", 1'b0, 16'hDEAD, 16'hBEEF, 16'h5555, 4'b0000, 1'b0);
    add_vec("hold2", 1'b0, 16'h0F0F, 16'hF0F0, 16'h5555, 4'b0000, 1'b0);
    add_vec("max_nc", 1'b1, 16'hF0A5, 16'h0F4A, 16'hFFEF, 4'b0000, 1'b1);

    // Reset with live operands: outputs must stay cleared across edges.
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    #1;
    check_all("reset_async", 16'h0000, 4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_all("reset_held", 16'h0000, 4'b0000, 1'b0);

    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    check_all("post_reset_idle", 16'h0000, 4'b0000, 1'b0);

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      check_all(vecs[i].name, vecs[i].exp_c, vecs[i].exp_ovf, vecs[i].exp_ov);
    end

    // Mid-stream asynchronous reset: results streaming, rst between edges.
    in_valid = 1'b1; a = 16'h0101; b = 16'h0202;
    @(posedge clk); #1;
    check_all("stream_pre_rst", 16'h0303, 4'b0000, 1'b1);
    a = 16'hFFFF; b = 16'h0001;
    #2 rst = 1'b1;
    #1;
    check_all("mid_rst_clear", 16'h0000, 4'b0000, 1'b0);
    // Operands sampled while rst is high must be dropped.
    @(posedge clk); #1;
    check_all("mid_rst_discard", 16'h0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_all("rel_idle", 16'h0000, 4'b0000, 1'b0);
    in_valid = 1'b1; a = 16'h4321; b = 16'h0102;
    @(posedge clk); #1;
    check_all("resume", 16'h4423, 4'b0000, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_all("resume_drop", 16'h4423, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
